// File: rtl/chunked_sub_pkg.sv
// Shared definitions for the chunked ripple-borrow subtractor: FSM encoding
// and chunk-count helpers used to size the datapath.
package chunked_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int num_chunks(input int n, input int w);
        return n / w;
    endfunction

    function automatic int idx_width(input int k);
        return $clog2(k) + 1;
    endfunction

endpackage

// File: rtl/chunked_sub_if.sv
// Operand/result handshake bundle for chunked_sub. The master side supplies
// operands and consumes results; the slave side is the subtractor.
interface chunked_sub_if #(
    parameter int N = 32
) ();

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );

endinterface

// File: rtl/chunked_sub_sub_chunk.sv
// Combinational W-bit ripple-borrow slice: {o_bo, o_d} = i_x - i_y - i_bi.
module sub_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    input  logic         i_bi,
    output logic [W-1:0] o_d,
    output logic         o_bo
);

    always_comb begin
        logic w_b;
        // NOTE: blocking assignments here model the borrow rippling bit by bit;
        // every output gets a default first so no latch is inferred.
        w_b = i_bi;
        o_d = '0;
        for (int i = 0; i < W; i++) begin
            o_d[i] = i_x[i] ^ i_y[i] ^ w_b;
            w_b    = (~i_x[i] & i_y[i]) | (~(i_x[i] ^ i_y[i]) & w_b);
        end
        o_bo = w_b;
    end

endmodule

// File: rtl/chunked_sub.sv
// Multi-cycle subtractor: one shared W-bit borrow slice walks the K chunks of
// the registered operands, carrying the borrow in a register between cycles.
module chunked_sub
    import chunked_sub_pkg::*;
#(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    chunked_sub_if.slave   io_bus
);

    localparam int K    = num_chunks(N, W);
    localparam int IDXW = idx_width(K);
    localparam int SELW = (K > 1) ? $clog2(K) : 1;

    generate
        if (N % W != 0) begin : g_bad_width
            $error("chunked_sub: N must be a multiple of W");
        end
    endgenerate

    state_t               r_state;
    logic [K-1:0][W-1:0]  r_a;
    logic [K-1:0][W-1:0]  r_b;
    logic [K-1:0][W-1:0]  r_diff;
    logic                 r_brw;
    logic [IDXW-1:0]      r_idx;
    logic                 r_out_valid;
    logic                 r_bout;
    logic                 r_ovf;

    logic [SELW-1:0]      w_sel;
    logic                 w_last;
    logic                 w_accept;
    logic [W-1:0]         w_d;
    logic                 w_bo;

    assign w_sel    = r_idx[SELW-1:0];
    assign w_last   = (r_idx == IDXW'(K - 1));
    assign w_accept = io_bus.in_valid & io_bus.in_ready;

    sub_chunk #(.W(W)) u_sub_chunk (
        .i_x  (r_a[w_sel]),
        .i_y  (r_b[w_sel]),
        .i_bi (r_brw),
        .o_d  (w_d),
        .o_bo (w_bo)
    );

    // NOTE: operand registers carry no reset; they are only read in BUSY,
    // which is reachable solely through a capture that overwrites them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= io_bus.a;
            r_b <= io_bus.b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_idx       <= '0;
            r_brw       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.in_valid) begin
                        r_brw   <= io_bus.bin;
                        r_idx   <= '0;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_diff[w_sel] <= w_d;
                    r_brw         <= w_bo;
                    r_idx         <= r_idx + IDXW'(1);
                    if (w_last) begin
                        // Overflow uses the sign of the final diff, i.e. the top bit of this slice.
                        r_bout      <= w_bo;
                        r_ovf       <= (r_a[K-1][W-1] ^ r_b[K-1][W-1])
                                     & (r_a[K-1][W-1] ^ w_d[W-1]);
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (io_bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign io_bus.in_ready  = (r_state == ST_IDLE) & ~rst;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.diff      = r_diff;
    assign io_bus.bout      = r_bout;
    assign io_bus.ovf       = r_ovf;

endmodule

// File: tb/tb_chunked_sub.sv
// Self-checking bench for chunked_sub: directed corner cases plus randomized
// operations scored against a plain-arithmetic reference model.
module tb_chunked_sub;

    localparam int N = 32;
    localparam int W = 8;
    localparam int K = N / W;
    localparam int WAIT_LIMIT = 4 * K + 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    chunked_sub_if #(.N(N)) bus ();

    chunked_sub #(.N(N), .W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: widen to N+1 bits; the top bit of the difference is the borrow.
    task automatic ref_sub(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                           output logic [N-1:0] d, output logic bo, output logic ov);
        logic [N:0] full;
        full = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bin};
        d    = full[N-1:0];
        bo   = full[N];
        ov   = (a[N-1] ^ b[N-1]) & (a[N-1] ^ d[N-1]);
    endtask

    // Called at a negedge; returns at the negedge just after the accept edge.
    task automatic start_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic bin);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.bin      = bin;
        while (!bus.in_ready && waited < WAIT_LIMIT) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_accept"}, bus.in_ready, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.bin      = 1'($urandom);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < WAIT_LIMIT) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic bin, input logic [N-1:0] ed, input logic eb,
                         input logic eo, input int stall);
        int lat;
        start_op(tag, a, b, bin);
        wait_result(lat);
        check({tag, "_latency"}, lat, K);
        bus.out_ready = 1'b0;
        repeat (stall) @(negedge clk);
        check({tag, "_valid"}, bus.out_valid, 1'b1);
        check({tag, "_in_ready"}, bus.in_ready, 1'b0);
        check({tag, "_diff"}, bus.diff, ed);
        check({tag, "_bout"}, bus.bout, eb);
        check({tag, "_ovf"}, bus.ovf, eo);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_valid_clr"}, bus.out_valid, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] a, b, ed;
        logic         bin, eb, eo;
        int           lat;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_diff", bus.diff, '0);
        check("rst_bout", bus.bout, 1'b0);
        check("rst_ovf", bus.ovf, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", bus.in_ready, 1'b1);

        do_op("v_small", 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 0);
        do_op("v_wrap",  32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1);
        do_op("v_ovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 0);
        do_op("v_chain", 32'h0000_0100, 32'h0000_0001, 1'b1, 32'h0000_00FE, 1'b0, 1'b0, 2);
        do_op("v_eqbin", 32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);

        // Stall in DONE with a competing operand set presented the whole time.
        start_op("stall", 32'h0000_0005, 32'h0000_0003, 1'b0);
        wait_result(lat);
        check("stall_latency", lat, K);
        bus.in_valid = 1'b1;
        bus.a        = 32'h0000_1234;
        bus.b        = 32'h0000_0234;
        bus.bin      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", bus.out_valid, 1'b1);
            check("stall_in_ready", bus.in_ready, 1'b0);
            check("stall_diff", bus.diff, 32'h0000_0002);
            check("stall_bout", bus.bout, 1'b0);
            check("stall_ovf", bus.ovf, 1'b0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("stall_release_valid", bus.out_valid, 1'b0);
        check("stall_release_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("stall_next_busy", bus.in_ready, 1'b0);
        wait_result(lat);
        check("stall_next_latency", lat, K);
        check("stall_next_diff", bus.diff, 32'h0000_1000);
        check("stall_next_bout", bus.bout, 1'b0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;

        // Abort with a one-cycle reset while the third chunk is pending.
        start_op("abort", 32'h1234_5678, 32'h0FED_CBA9, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", bus.out_valid, 1'b0);
        check("abort_diff", bus.diff, '0);
        @(negedge clk);
        check("abort_in_ready", bus.in_ready, 1'b1);
        for (int i = 0; i < K + 2; i++) begin
            check("abort_no_valid", bus.out_valid, 1'b0);
            @(negedge clk);
        end
        ref_sub(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, ed, eb, eo);
        do_op("post_abort", 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, ed, eb, eo, 1);

        for (int i = 0; i < 2000; i++) begin
            a   = $urandom;
            b   = $urandom;
            bin = 1'($urandom);
            case ($urandom_range(0, 7))
                0: a = b;
                1: a = '0;
                2: b = '1;
                3: b = a + {{(N-1){1'b0}}, 1'b1};
                default: ;
            endcase
            ref_sub(a, b, bin, ed, eb, eo);
            do_op("rnd", a, b, bin, ed, eb, eo, int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
